// File: rtl/types.sv
// Shared widths and message formats for the snooping bus and the crossbar.
//   XLEN           : line address width (the line store holds 2^XLEN lines)
//   CACHELINE_SIZE : bits per cache line
//   NUM_CPUS       : number of cache controllers addressable on the crossbar
package types;

    localparam int XLEN           = 4;
    localparam int CACHELINE_SIZE = 8;
    localparam int NUM_CPUS       = 2;
    localparam int CPU_W          = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

    typedef enum logic [1:0] {
        Bus_Idle = 2'd0,
        Bus_Rd   = 2'd1,
        Bus_RdX  = 2'd2,
        Bus_Upgr = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic             valid;
        bus_tx_t          bus_tx;
        logic [CPU_W-1:0] source;
        logic [XLEN-1:0]  addr;
    } bus_msg_t;

    typedef struct packed {
        logic                      valid;
        logic [CPU_W-1:0]          destination;
        logic [XLEN-1:0]           addr;
        logic [CACHELINE_SIZE-1:0] data;
    } xbar_msg_t;

endpackage

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder on the snooping bus.
// Queues Bus_Rd requests, reads the line store after MEM_LATENCY wait cycles
// and returns the line on the crossbar to the requester. Writebacks are
// absorbed into the line store on any cycle.
//
// Optional build macro: MEM_RESP_INTERVENTION_EN adds the snoop_hit input;
// a Bus_Rd accepted while snoop_hit=1 is dropped (a peer cache supplies it).
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus_in      : snooped bus transaction
//   bus_stall   : request queue full, requester must hold its request
//   wb_valid/wb_addr/wb_data : writeback strobe, line address, line data
//   xbar_out    : response message to the crossbar
//   xbar_ready  : crossbar accepts xbar_out this cycle
//   busy        : queue non-empty or a request in service
//   snoop_hit   : (MEM_RESP_INTERVENTION_EN only) peer cache intervenes
//   state_dbg   : current FSM state (0=IDLE, 1=WAIT, 2=RESP)
//
// Handshake: xbar_out is valid while the FSM is in RESP; it is held stable
// until a rising edge sees xbar_ready=1, at which point the response is
// consumed and valid drops in the following cycle.
module mem_responder
    import types::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  bus_msg_t                  bus_in,
    output logic                      bus_stall,
    input  logic                      wb_valid,
    input  logic [XLEN-1:0]           wb_addr,
    input  logic [CACHELINE_SIZE-1:0] wb_data,
    output xbar_msg_t                 xbar_out,
    input  logic                      xbar_ready,
    output logic                      busy,
`ifdef MEM_RESP_INTERVENTION_EN
    input  logic                      snoop_hit,
`endif
    output logic [1:0]                state_dbg
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int LW    = $clog2(MEM_LATENCY + 1);
    localparam int LINES = 2 ** XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CACHELINE_SIZE-1:0] lines [LINES];

    logic [CPU_W-1:0] q_src  [FIFO_DEPTH];
    logic [XLEN-1:0]  q_addr [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic [LW-1:0]             cnt;
    logic [CPU_W-1:0]          cur_src;
    logic [XLEN-1:0]           cur_addr;
    logic [CACHELINE_SIZE-1:0] cap_data;
    logic [CACHELINE_SIZE-1:0] rd_data;

    logic push, pop;

    // Stall depends only on the count, so a full queue keeps stalling even in
    // a cycle where the FSM pops.
    assign bus_stall = (count == CW'(FIFO_DEPTH));
    assign pop       = (state == IDLE) && (count != '0);

    always_comb begin
        push = bus_in.valid && (bus_in.bus_tx == Bus_Rd) && !bus_stall;
`ifdef MEM_RESP_INTERVENTION_EN
        push = push && !snoop_hit;
`endif
    end

    // Write-first: a writeback to the line being captured wins.
    assign rd_data = (wb_valid && (wb_addr == cur_addr)) ? wb_data : lines[cur_addr];

    // Line store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (wb_valid) begin
            lines[wb_addr] <= wb_data;
        end
    end

    // Request queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_src[wr_ptr]  <= bus_in.source;
                q_addr[wr_ptr] <= bus_in.addr;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pop)               state_next = WAIT;
            WAIT: if (cnt == LW'(1))     state_next = RESP;
            RESP: if (xbar_ready)        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Request in service: latched on pop, line captured on the last wait cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cur_src  <= '0;
            cur_addr <= '0;
            cap_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_src  <= q_src[rd_ptr];
                        cur_addr <= q_addr[rd_ptr];
                        cnt      <= LW'(MEM_LATENCY);
                    end
                end
                WAIT: begin
                    if (cnt == LW'(1)) begin
                        cap_data <= rd_data;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        xbar_out = '0;
        if (state == RESP) begin
            xbar_out.valid       = 1'b1;
            xbar_out.destination = cur_src;
            xbar_out.addr        = cur_addr;
            xbar_out.data        = cap_data;
        end
    end

    assign busy      = (count != '0) || (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, single read latency, writeback,
// write-first capture, queue full/stall with ordered responses, ignored bus
// traffic, reset mid-operation, back-to-back timing and (when built with
// MEM_RESP_INTERVENTION_EN) snoop intervention.
module tb_mem_responder;
    import types::*;

    localparam int MW = $bits(xbar_msg_t);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    bus_msg_t                  bus_in = '0;
    logic                      bus_stall;
    logic                      wb_valid = 1'b0;
    logic [XLEN-1:0]           wb_addr = '0;
    logic [CACHELINE_SIZE-1:0] wb_data = '0;
    xbar_msg_t                 xbar_out;
    logic                      xbar_ready = 1'b0;
    logic                      busy;
    logic [1:0]                state_dbg;
`ifdef MEM_RESP_INTERVENTION_EN
    logic                      snoop_hit = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [MW-1:0] exp_q [$];

    mem_responder #(.FIFO_DEPTH(4), .MEM_LATENCY(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .bus_stall  (bus_stall),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .xbar_out   (xbar_out),
        .xbar_ready (xbar_ready),
        .busy       (busy),
`ifdef MEM_RESP_INTERVENTION_EN
        .snoop_hit  (snoop_hit),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic xbar_msg_t mk_resp(input logic [CPU_W-1:0] d, input logic [XLEN-1:0] a,
                                          input logic [CACHELINE_SIZE-1:0] data);
        xbar_msg_t m;
        m.valid       = 1'b1;
        m.destination = d;
        m.addr        = a;
        m.data        = data;
        return m;
    endfunction

    task automatic drive_rd(input logic [CPU_W-1:0] src, input logic [XLEN-1:0] a);
        bus_in.valid  = 1'b1;
        bus_in.bus_tx = Bus_Rd;
        bus_in.source = src;
        bus_in.addr   = a;
    endtask

    task automatic clear_bus();
        bus_in = '0;
    endtask

    // Writeback for one cycle, starting at the current negedge.
    task automatic do_wb(input logic [XLEN-1:0] a, input logic [CACHELINE_SIZE-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Advance negedges until xbar_out.valid is seen or the budget runs out.
    task automatic wait_valid(input int max_cycles, output bit got);
        got = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (xbar_out.valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (xbar_out !== '0) begin
            bad++; $display("FAIL reset_xbar: got %h want 0", xbar_out);
        end
        total++;
        if (bus_stall !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got stall=%b busy=%b want 0 0", bus_stall, busy);
        end
        total++;
        if (state_dbg !== 2'd0) begin
            bad++; $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || xbar_out !== '0) begin
            bad++; $display("FAIL post_reset_idle: got busy=%b xbar=%h want 0 0", busy, xbar_out);
        end
    endtask

    // Accept at E0; valid only on the 5th negedge after driving (E4..E5).
    task automatic test_basic_read();
        xbar_out_t_check: begin end
        xbar_ready = 1'b1;
        drive_rd(1'b1, 4'd5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) clear_bus();
            total++;
            if (xbar_out.valid !== (k == 5)) begin
                bad++; $display("FAIL basic_valid_k%0d: got %b want %b", k, xbar_out.valid, (k == 5));
            end
            if (k == 5) begin
                total++;
                if (xbar_out !== mk_resp(1'b1, 4'd5, 8'h00)) begin
                    bad++; $display("FAIL basic_msg: got %h want %h", xbar_out, mk_resp(1'b1, 4'd5, 8'h00));
                end
            end
        end
    endtask

    task automatic test_writeback();
        bit got;
        xbar_ready = 1'b1;
        do_wb(4'd5, 8'hA5);
        drive_rd(1'b0, 4'd5);
        @(negedge clk);
        clear_bus();
        wait_valid(20, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL wb_timeout: got no response want response");
        end else begin
            total++;
            if (xbar_out !== mk_resp(1'b0, 4'd5, 8'hA5)) begin
                bad++; $display("FAIL wb_msg: got %h want %h", xbar_out, mk_resp(1'b0, 4'd5, 8'hA5));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Writeback lands in the capture cycle (WAIT with counter at 1).
    task automatic test_collision();
        xbar_ready = 1'b1;
        drive_rd(1'b1, 4'd5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) clear_bus();
            if (k == 4) begin
                wb_valid = 1'b1;
                wb_addr  = 4'd5;
                wb_data  = 8'h3C;
            end
            if (k == 5) begin
                wb_valid = 1'b0;
                total++;
                if (xbar_out !== mk_resp(1'b1, 4'd5, 8'h3C)) begin
                    bad++; $display("FAIL collision_msg: got %h want %h", xbar_out, mk_resp(1'b1, 4'd5, 8'h3C));
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // First request goes into service, the next four fill the queue, the
    // sixth is held by bus_stall until space frees.
    task automatic test_stall_order();
        logic [XLEN-1:0]           addrs [6];
        logic [CACHELINE_SIZE-1:0] datas [6];
        int  nresp;
        bit  f_acc;
        addrs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        datas = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h3C, 8'h66};
        do_wb(4'd1, 8'h11);
        do_wb(4'd2, 8'h22);
        do_wb(4'd3, 8'h33);
        do_wb(4'd4, 8'h44);
        do_wb(4'd6, 8'h66);
        xbar_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rd(CPU_W'(i % 2), addrs[i]);
            exp_q.push_back(mk_resp(CPU_W'(i % 2), addrs[i], datas[i]));
            @(negedge clk);
            if (i == 3) begin
                total++;
                if (bus_stall !== 1'b0) begin
                    bad++; $display("FAIL stall_early: got %b want 0", bus_stall);
                end
            end
            if (i == 4) begin
                total++;
                if (bus_stall !== 1'b1) begin
                    bad++; $display("FAIL stall_full: got %b want 1", bus_stall);
                end
            end
        end
        drive_rd(CPU_W'(1), addrs[5]);
        exp_q.push_back(mk_resp(CPU_W'(1), addrs[5], datas[5]));
        for (int c = 0; c < 10; c++) begin
            total++;
            if (xbar_out !== xbar_msg_t'(exp_q[0])) begin
                bad++; $display("FAIL hold_stable_c%0d: got %h want %h", c, xbar_out, exp_q[0]);
            end
            total++;
            if (bus_stall !== 1'b1) begin
                bad++; $display("FAIL hold_stall_c%0d: got %b want 1", c, bus_stall);
            end
            @(negedge clk);
        end
        xbar_ready = 1'b1;
        nresp = 0;
        f_acc = 1'b0;
        for (int c = 0; c < 100 && nresp < 6; c++) begin
            if (f_acc) clear_bus();
            else if (!bus_stall) f_acc = 1'b1;
            if (xbar_out.valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL order_extra: got %h want none", xbar_out);
                end else if (xbar_out !== xbar_msg_t'(exp_q[0])) begin
                    bad++; $display("FAIL order_resp%0d: got %h want %h", nresp, xbar_out, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                nresp++;
            end
            @(negedge clk);
        end
        clear_bus();
        total++;
        if (nresp != 6 || !f_acc) begin
            bad++; $display("FAIL order_count: got resp=%0d held_accepted=%b want 6 1", nresp, f_acc);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_traffic();
        xbar_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                bus_in.valid  = 1'b0;
                bus_in.bus_tx = bus_tx_t'($urandom_range(0, 3));
            end else begin
                bus_in.valid  = 1'b1;
                bus_in.bus_tx = ($urandom_range(0, 1) == 0) ? Bus_Idle : Bus_RdX;
            end
            bus_in.source = CPU_W'($urandom_range(0, NUM_CPUS - 1));
            bus_in.addr   = XLEN'($urandom_range(0, 15));
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || xbar_out.valid !== 1'b0) begin
                bad++; $display("FAIL idle_traffic_c%0d: got busy=%b valid=%b want 0 0", c, busy, xbar_out.valid);
            end
        end
        clear_bus();
    endtask

    task automatic test_reset_mid();
        bit got;
        xbar_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rd(CPU_W'(i % 2), XLEN'(i + 1));
            @(negedge clk);
        end
        clear_bus();
        total++;
        if (state_dbg !== 2'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_prestate: got state=%0d busy=%b want 1 1", state_dbg, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (xbar_out !== '0 || busy !== 1'b0 || bus_stall !== 1'b0 || state_dbg !== 2'd0) begin
            bad++; $display("FAIL mid_reset_outputs: got xbar=%h busy=%b stall=%b state=%0d want 0 0 0 0",
                            xbar_out, busy, bus_stall, state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        xbar_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            total++;
            if (xbar_out.valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_no_resp_c%0d: got valid=%b busy=%b want 0 0", c, xbar_out.valid, busy);
            end
        end
        // Line store was cleared: address 1 held 0x11 before the reset.
        drive_rd(1'b0, 4'd1);
        @(negedge clk);
        clear_bus();
        wait_valid(20, got);
        total++;
        if (!got || xbar_out !== mk_resp(1'b0, 4'd1, 8'h00)) begin
            bad++; $display("FAIL mid_store_cleared: got got=%b msg=%h want 1 %h", got, xbar_out, mk_resp(1'b0, 4'd1, 8'h00));
        end
        repeat (2) @(negedge clk);
    endtask

    // Two requests one cycle apart: responses 5 cycles apart.
    task automatic test_back_to_back();
        xbar_ready = 1'b1;
        do_wb(4'd3, 8'h5A);
        do_wb(4'd4, 8'hC3);
        drive_rd(1'b0, 4'd3);
        @(negedge clk);
        drive_rd(1'b1, 4'd4);
        for (int k = 2; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) clear_bus();
            total++;
            if (xbar_out.valid !== (k == 5 || k == 10)) begin
                bad++; $display("FAIL b2b_valid_k%0d: got %b want %b", k, xbar_out.valid, (k == 5 || k == 10));
            end
            if (k == 5) begin
                total++;
                if (xbar_out !== mk_resp(1'b0, 4'd3, 8'h5A)) begin
                    bad++; $display("FAIL b2b_first: got %h want %h", xbar_out, mk_resp(1'b0, 4'd3, 8'h5A));
                end
            end
            if (k == 10) begin
                total++;
                if (xbar_out !== mk_resp(1'b1, 4'd4, 8'hC3)) begin
                    bad++; $display("FAIL b2b_second: got %h want %h", xbar_out, mk_resp(1'b1, 4'd4, 8'hC3));
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_RESP_INTERVENTION_EN
    task automatic test_intervention();
        bit got;
        xbar_ready = 1'b1;
        snoop_hit  = 1'b1;
        drive_rd(1'b1, 4'd2);
        @(negedge clk);
        clear_bus();
        snoop_hit = 1'b0;
        wait_valid(15, got);
        total++;
        if (got || busy !== 1'b0) begin
            bad++; $display("FAIL snoop_dropped: got resp=%b busy=%b want 0 0", got, busy);
        end
        drive_rd(1'b1, 4'd2);
        @(negedge clk);
        clear_bus();
        wait_valid(20, got);
        total++;
        if (!got || xbar_out !== mk_resp(1'b1, 4'd2, 8'h00)) begin
            bad++; $display("FAIL snoop_miss_resp: got got=%b msg=%h want 1 %h", got, xbar_out, mk_resp(1'b1, 4'd2, 8'h00));
        end
        repeat (2) @(negedge clk);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_writeback();
        test_collision();
        test_stall_order();
        test_idle_traffic();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_RESP_INTERVENTION_EN
        test_intervention();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
